slice_line_mux_bp: RTL and testbench

Parametrised successor of the decoder's slice output multiplexer. It sits in the clk_out_int domain after the per-slice output sync FIFOs. It reads the FIFOs in slice order to rebuild raster display lines, and emits a PIXS_PER_CYCLE-wide pixel word per beat. Over the previous generation it adds:
- configurable pixel/component width;
- per-pixel valid masks for partial words, derived internally from slice_width;
- a ready/valid output with full backpressure;
- explicit sof/eol/eof framing and a start-of-frame misalignment error.

---
 rtl/slice_line_mux_bp_pkg.sv | 15 +
 rtl/slice_line_mux_bp_skid_fifo2.sv | 30 +++
 rtl/slice_line_mux_bp.sv | 134 +++++++++++++
 tb/tb_slice_line_mux_bp.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/slice_line_mux_bp_pkg.sv
// slice_line_mux_bp_pkg: shared types and helpers for the slice line multiplexer
package slice_line_mux_bp_pkg;
  localparam int MAX_PPC = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
    logic [MAX_PPC-1:0] mask;
  } tag_t;
  localparam int TAG_W = $bits(tag_t);
  function automatic int word_width(input int ppc, input int cw);
    return ppc * 3 * cw;
  endfunction
endpackage

// File: rtl/slice_line_mux_bp_skid_fifo2.sv
// skid_fifo2: two-entry synchronous FIFO with occupancy count; entry e0 is always the head
module skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk_out_int,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] e0, e1;
  assign dout = e0;
  always_ff @(posedge clk_out_int or posedge rst) begin
    if (rst) begin
      e0    <= '0;
      e1    <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (push & (count == 2'd0 | (count == 2'd1 & pop))) e0 <= din;
      else if (pop & count == 2'd2) e0 <= e1;
      if (push & (count == 2'd2 | (count == 2'd1 & ~pop))) e1 <= din;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/slice_line_mux_bp.sv
// slice_line_mux_bp: reads slice FIFOs in order and emits masked, framed pixel words with backpressure
module slice_line_mux_bp
  import slice_line_mux_bp_pkg::*;
#(
  parameter int MAX_NBR_SLICES  = 4,
  parameter int PIXS_PER_CYCLE  = 4,
  parameter int COMP_WIDTH      = 14,
  parameter int MAX_SLICE_WIDTH = 2560
) (
  input  logic                                               clk_out_int,
  input  logic                                               rst,
  input  logic                                               flush,
  input  logic                                               start,
  input  logic [$clog2(MAX_NBR_SLICES+1)-1:0]                slices_per_line,
  input  logic [$clog2(MAX_SLICE_WIDTH+1)-1:0]               slice_width,
  input  logic [15:0]                                        frame_height,
  input  logic [MAX_NBR_SLICES-1:0]                          fifo_empty,
  output logic [MAX_NBR_SLICES-1:0]                          fifo_rd_en,
  input  logic [MAX_NBR_SLICES*PIXS_PER_CYCLE*3*COMP_WIDTH-1:0] fifo_rd_data,
  input  logic [MAX_NBR_SLICES-1:0]                          fifo_rd_sof,
  output logic [PIXS_PER_CYCLE*3*COMP_WIDTH-1:0]             pixs_out,
  output logic [PIXS_PER_CYCLE-1:0]                          pixs_out_mask,
  output logic                                               pixs_out_sof,
  output logic                                               pixs_out_eol,
  output logic                                               pixs_out_eof,
  output logic                                               pixs_out_valid,
  input  logic                                               pixs_out_ready,
  output logic                                               sof_err
);
  localparam int PW    = word_width(PIXS_PER_CYCLE, COMP_WIDTH);
  localparam int SPL_W = $clog2(MAX_NBR_SLICES+1);
  localparam int SW_W  = $clog2(MAX_SLICE_WIDTH+1);
  localparam int SEL_W = $clog2(MAX_NBR_SLICES);
  localparam int LP_W  = $clog2(PIXS_PER_CYCLE+1);
  localparam int SH    = $clog2(PIXS_PER_CYCLE);
  localparam int SK_W  = PW + TAG_W;
  state_t state, state_nxt;
  logic [SPL_W-1:0] spl;
  logic [SW_W-1:0] words, word_cnt, words_in;
  logic [SW_W:0] sw_ext;
  logic [LP_W-1:0] last_pixs, last_pixs_in;
  logic [15:0] fh, line_cnt;
  logic [SEL_W-1:0] sel, inflight_sel;
  logic inflight, rd_ok, last_word, last_sel, last_line, pop, push;
  logic [1:0] skid_count;
  logic [SK_W-1:0] skid_dout;
  logic [PIXS_PER_CYCLE-1:0] full_mask, last_mask;
  tag_t tag, inflight_tag, head_tag;
  assign sw_ext       = {1'b0, slice_width} + (SW_W+1)'(PIXS_PER_CYCLE-1);
  assign words_in     = SW_W'(sw_ext >> SH);
  assign last_pixs_in = LP_W'((slice_width - SW_W'(1)) & SW_W'(PIXS_PER_CYCLE-1)) + LP_W'(1);
  assign last_word    = word_cnt == words - SW_W'(1);
  assign last_sel     = SPL_W'(sel) == spl - SPL_W'(1);
  assign last_line    = line_cnt == fh - 16'd1;
  assign full_mask    = '1;
  assign last_mask    = full_mask >> (LP_W'(PIXS_PER_CYCLE) - last_pixs);
  assign tag.sof      = line_cnt == 16'd0 & sel == '0 & word_cnt == '0;
  assign tag.eol      = last_word & last_sel;
  assign tag.eof      = last_word & last_sel & last_line;
  assign tag.mask     = MAX_PPC'(last_word ? last_mask : full_mask);
  assign pixs_out_valid = skid_count != 2'd0;
  assign pop  = pixs_out_valid & pixs_out_ready;
  assign push = inflight & ~flush;
  // occupancy net of this cycle's pop keeps one word per cycle with ready high
  assign rd_ok = state == RUN & ~fifo_empty[sel] &
                 (3'(skid_count) - 3'(pop) + 3'(inflight) < 3'd2);
  always_ff @(posedge clk_out_int or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = flush ? IDLE :
                state == IDLE ? (start ? RUN : IDLE) :
                state == RUN ? (rd_ok & tag.eof ? DRAIN : RUN) :
                (pop & head_tag.eof ? IDLE : DRAIN);
  end
  always_comb begin
    fifo_rd_en      = '0;
    fifo_rd_en[sel] = rd_ok;
  end
  always_ff @(posedge clk_out_int or posedge rst) begin
    if (rst) begin
      spl          <= '0;
      words        <= '0;
      last_pixs    <= '0;
      fh           <= '0;
      sel          <= '0;
      word_cnt     <= '0;
      line_cnt     <= '0;
      inflight     <= 1'b0;
      inflight_sel <= '0;
      inflight_tag <= '0;
      sof_err      <= 1'b0;
    end else begin
      inflight     <= rd_ok & ~flush;
      inflight_sel <= sel;
      inflight_tag <= tag;
      if (push & (fifo_rd_sof[inflight_sel] != inflight_tag.sof)) sof_err <= 1'b1;
      if (flush) begin
        sel      <= '0;
        word_cnt <= '0;
        line_cnt <= '0;
      end else if (state == IDLE & start) begin
        spl       <= slices_per_line;
        words     <= words_in;
        last_pixs <= last_pixs_in;
        fh        <= frame_height;
        sel       <= '0;
        word_cnt  <= '0;
        line_cnt  <= '0;
      end else if (rd_ok) begin
        word_cnt <= last_word ? '0 : word_cnt + SW_W'(1);
        if (last_word) sel <= last_sel ? '0 : sel + SEL_W'(1);
        if (last_word & last_sel) line_cnt <= line_cnt + 16'd1;
      end
    end
  end
  skid_fifo2 #(.W(SK_W)) u_skid (
    .clk_out_int(clk_out_int),
    .rst        (rst),
    .flush      (flush),
    .push       (push),
    .din        ({inflight_tag, fifo_rd_data[inflight_sel*PW +: PW]}),
    .pop        (pop),
    .dout       (skid_dout),
    .count      (skid_count)
  );
  assign head_tag      = tag_t'(skid_dout[SK_W-1 -: TAG_W]);
  assign pixs_out      = skid_dout[PW-1:0];
  assign pixs_out_sof  = pixs_out_valid & head_tag.sof;
  assign pixs_out_eol  = pixs_out_valid & head_tag.eol;
  assign pixs_out_eof  = pixs_out_valid & head_tag.eof;
  assign pixs_out_mask = pixs_out_valid ? head_tag.mask[PIXS_PER_CYCLE-1:0] : '0;
endmodule

// File: tb/tb_slice_line_mux_bp.sv
// tb_slice_line_mux_bp: directed self-checking bench with a behavioural slice FIFO model
module tb_slice_line_mux_bp;
  localparam int N  = 4;
  localparam int P  = 4;
  localparam int CW = 14;
  localparam int MSW = 2560;
  localparam int PW = P * 3 * CW;
  localparam int EW = PW + 3 + P;
  logic clk_out_int = 1'b0;
  logic rst = 1'b1, flush = 1'b0, start = 1'b0;
  logic [$clog2(N+1)-1:0] slices_per_line = '0;
  logic [$clog2(MSW+1)-1:0] slice_width = '0;
  logic [15:0] frame_height = '0;
  logic [N-1:0] fifo_empty = '0, fifo_rd_en, fifo_rd_sof = '0;
  logic [N*PW-1:0] fifo_rd_data = '0;
  logic [PW-1:0] pixs_out;
  logic [P-1:0] pixs_out_mask;
  logic pixs_out_sof, pixs_out_eol, pixs_out_eof, pixs_out_valid, sof_err;
  logic pixs_out_ready = 1'b1;
  int checks = 0, failures = 0;
  int cfg_spl, cfg_w, cfg_lp, cfg_fh;
  int rc[N];
  int gcnt, ocnt, cyc, first_valid, rsel, rword, ready_mode, e_from, e_to;
  bit inj, last_valid, last_ready;
  logic [EW-1:0] last_cur;
  logic [P-1:0] obs_mask[64];
  bit obs_sof[64], obs_eol[64], obs_eof[64];

  slice_line_mux_bp #(.MAX_NBR_SLICES(N), .PIXS_PER_CYCLE(P), .COMP_WIDTH(CW), .MAX_SLICE_WIDTH(MSW)) dut (
    .clk_out_int(clk_out_int), .rst(rst), .flush(flush), .start(start),
    .slices_per_line(slices_per_line), .slice_width(slice_width), .frame_height(frame_height),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_sof(fifo_rd_sof),
    .pixs_out(pixs_out), .pixs_out_mask(pixs_out_mask), .pixs_out_sof(pixs_out_sof),
    .pixs_out_eol(pixs_out_eol), .pixs_out_eof(pixs_out_eof), .pixs_out_valid(pixs_out_valid),
    .pixs_out_ready(pixs_out_ready), .sof_err(sof_err)
  );

  always #5 clk_out_int = ~clk_out_int;

  task automatic chk(input string t, input logic [255:0] o, input logic [255:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  function automatic logic [PW-1:0] pat(input int s, input int n);
    logic [PW-1:0] d = '0;
    d[15:0] = 16'(s * 4096 + n);
    d[80 +: 16] = 16'(n * 7 + s + 1);
    d[PW-1 -: 16] = ~16'(s * 4096 + n);
    return d;
  endfunction

  function automatic logic [EW-1:0] expw(input int i);
    int lw, line, r, s, w;
    logic [P-1:0] m;
    logic eol;
    lw = cfg_w * cfg_spl;
    line = i / lw;
    r = i % lw;
    s = r / cfg_w;
    w = r % cfg_w;
    m = (w == cfg_w - 1) ? P'((1 << cfg_lp) - 1) : '1;
    eol = r == lw - 1;
    return {pat(s, line * cfg_w + w), i == 0, eol, eol && line == cfg_fh - 1, m};
  endfunction

  task automatic tick();
    logic [N-1:0] rs;
    logic [EW-1:0] cur;
    @(negedge clk_out_int);
    cyc++;
    rs = fifo_rd_en;
    cur = {pixs_out, pixs_out_sof, pixs_out_eol, pixs_out_eof, pixs_out_mask};
    if (rs != '0) begin
      chk("rd_order", 256'(rs), 256'(N'(1) << rsel));
      if (rword == cfg_w - 1) begin
        rword = 0;
        rsel = (rsel == cfg_spl - 1) ? 0 : rsel + 1;
      end else rword++;
    end
    if (last_valid && !last_ready) chk("stall_hold", 256'(cur), 256'(last_cur));
    if (pixs_out_valid && first_valid < 0) first_valid = cyc;
    if (pixs_out_valid && pixs_out_ready) begin
      chk($sformatf("word%0d", ocnt), 256'(cur), 256'(expw(ocnt)));
      if (ocnt < 64) begin
        obs_mask[ocnt] = pixs_out_mask;
        obs_sof[ocnt] = pixs_out_sof;
        obs_eol[ocnt] = pixs_out_eol;
        obs_eof[ocnt] = pixs_out_eof;
      end
      ocnt++;
    end
    last_valid = pixs_out_valid;
    last_ready = pixs_out_ready;
    last_cur = cur;
    @(posedge clk_out_int);
    #1;
    for (int s = 0; s < N; s++) if (rs[s]) begin
      fifo_rd_data[s*PW +: PW] = pat(s, rc[s]);
      fifo_rd_sof[s] = (gcnt == 0) ^ (inj && gcnt == 3);
      rc[s]++;
      gcnt++;
    end
    pixs_out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0 && !(cyc >= 12 && cyc < 17));
    fifo_empty[1] = (cyc >= e_from && cyc < e_to);
  endtask

  task automatic start_frame(input int spl_, input int sw, input int fh_);
    cfg_spl = spl_;
    cfg_w = (sw + P - 1) / P;
    cfg_lp = sw - (cfg_w - 1) * P;
    cfg_fh = fh_;
    slices_per_line = 3'(spl_);
    slice_width = 12'(sw);
    frame_height = 16'(fh_);
    for (int s = 0; s < N; s++) rc[s] = 0;
    gcnt = 0; ocnt = 0; rsel = 0; rword = 0; first_valid = -1; last_valid = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    slices_per_line = 3'd1;
    slice_width = 12'd1;
    frame_height = 16'd1;
  endtask

  task automatic run_frame(input int n, input int budget);
    for (int i = 0; i < budget && ocnt < n; i++) tick();
    chk("frame_words", 256'(ocnt), 256'(n));
    @(negedge clk_out_int);
    chk("idle_valid", 256'(pixs_out_valid), 256'(0));
    chk("idle_rd_en", 256'(fifo_rd_en), 256'(0));
  endtask

  initial begin
    ready_mode = 0; e_from = -1; e_to = -1; inj = 0; cyc = 0;
    cfg_spl = 1; cfg_w = 1; cfg_lp = 1; cfg_fh = 1;
    #12;
    chk("rst_outputs", 256'({fifo_rd_en, pixs_out_valid, pixs_out_mask, pixs_out_sof, pixs_out_eol, pixs_out_eof, sof_err}), 256'(0));
    chk("rst_pixs", 256'(pixs_out), 256'(0));
    @(posedge clk_out_int); #1 rst = 1'b0;

    start_frame(2, 16, 2);
    run_frame(16, 100);
    chk("t1_latency", 256'(first_valid), 256'(3));
    chk("t1_sof0", 256'({obs_sof[0], obs_sof[1]}), 256'(2'b10));
    chk("t1_eol", 256'({obs_eol[6], obs_eol[7], obs_eol[15]}), 256'(3'b011));
    chk("t1_eof", 256'({obs_eof[7], obs_eof[15]}), 256'(2'b01));
    chk("t1_mask", 256'(obs_mask[3]), 256'(4'b1111));

    start_frame(3, 10, 2);
    run_frame(18, 150);
    chk("t2_mask", 256'({obs_mask[0], obs_mask[1], obs_mask[2], obs_mask[5], obs_mask[8]}), 256'(20'hFF333));
    chk("t2_eol", 256'({obs_eol[2], obs_eol[8], obs_eol[17]}), 256'(3'b011));
    chk("t2_eof", 256'({obs_eof[8], obs_eof[17]}), 256'(2'b01));

    ready_mode = 1;
    start_frame(2, 16, 2);
    run_frame(16, 400);
    ready_mode = 0;
    pixs_out_ready = 1'b1;

    e_from = 3; e_to = 23;
    start_frame(2, 16, 2);
    run_frame(16, 200);
    e_from = -1; e_to = -1;
    fifo_empty = '0;

    chk("sof_err_clean", 256'(sof_err), 256'(0));
    inj = 1;
    start_frame(2, 16, 1);
    run_frame(8, 100);
    inj = 0;
    chk("sof_err_set", 256'(sof_err), 256'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("sof_err_flush", 256'(sof_err), 256'(1));
    start_frame(2, 16, 1);
    run_frame(8, 100);
    chk("sof_err_sticky", 256'(sof_err), 256'(1));
    rst = 1'b1;
    #2;
    chk("sof_err_rst", 256'(sof_err), 256'(0));
    @(posedge clk_out_int); #1 rst = 1'b0;

    start_frame(2, 8, 4);
    for (int i = 0; i < 200 && ocnt < 6; i++) tick();
    chk("t6_mid", 256'(ocnt), 256'(6));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk_out_int);
    chk("t6_flush_valid", 256'(pixs_out_valid), 256'(0));
    chk("t6_flush_rd", 256'(fifo_rd_en), 256'(0));
    start_frame(2, 8, 4);
    run_frame(16, 200);
    chk("t6_sof", 256'({obs_sof[0], obs_eof[15]}), 256'(2'b11));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
